// File: rtl/shift_issue_stage.sv
// shift_issue_stage: ID->EX issue register for SLL/SRA/ROR; SHIFT_FWD_EN adds EX/MEM and MEM/WB forwarding of Rs
module shift_issue_stage #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [3:0]        id_opcode,
  input  logic [RA_W-1:0]   id_rs_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [RA_W-1:0]   id_rd_addr,
  input  logic [AMT_W-1:0]  id_imm,
  input  logic              flush,
  input  logic              exmem_wr_en,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr_en,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] Shift_In,
  output logic [AMT_W-1:0]  Shift_Val,
  output logic [1:0]        Mode,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [15:0]       shift_cnt
);
  logic              is_shift;
  logic              accept;
  logic [DATA_W-1:0] rs_val;
  assign is_shift = id_opcode inside {4'b0100, 4'b0101, 4'b0110};
  assign id_ready = ~ex_valid | ex_ready;
  assign accept   = id_valid & id_ready & is_shift & ~flush;
`ifdef SHIFT_FWD_EN
  logic rs_nz;
  assign rs_nz = |id_rs_addr;
  always_comb
    rs_val = (exmem_wr_en && exmem_rd == id_rs_addr && rs_nz) ? exmem_data :
             (memwb_wr_en && memwb_rd == id_rs_addr && rs_nz) ? memwb_data : id_rs_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_wr_en, exmem_rd, exmem_data, memwb_wr_en, memwb_rd, memwb_data};
  assign rs_val = id_rs_data;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      Shift_In  <= '0;
      Shift_Val <= '0;
      Mode      <= 2'b00;
      ex_rd     <= '0;
      shift_cnt <= '0;
    end else begin
      ex_valid <= flush ? 1'b0 : accept | (ex_valid & ~ex_ready);
      if (accept) begin
        Shift_In  <= rs_val;
        Shift_Val <= id_imm;
        Mode      <= id_opcode[1:0];
        ex_rd     <= id_rd_addr;
        shift_cnt <= shift_cnt + 16'(~&shift_cnt);
      end
    end
  end
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: vectors, corner sequences and random traffic against a behavioural model
module tb_shift_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready, flush, ex_valid, ex_ready;
  logic [3:0]  id_opcode, id_rs_addr, id_rd_addr, id_imm, exmem_rd, memwb_rd, Shift_Val, ex_rd;
  logic [15:0] id_rs_data, exmem_data, memwb_data, Shift_In, shift_cnt;
  logic        exmem_wr_en, memwb_wr_en;
  logic [1:0]  Mode;

  shift_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready), .id_opcode(id_opcode),
    .id_rs_addr(id_rs_addr), .id_rs_data(id_rs_data), .id_rd_addr(id_rd_addr), .id_imm(id_imm),
    .flush(flush), .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .Shift_In(Shift_In), .Shift_Val(Shift_Val), .Mode(Mode), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .shift_cnt(shift_cnt)
  );

  always #5 clk = ~clk;

`ifdef SHIFT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic        m_valid;
  logic [15:0] m_si;
  logic [3:0]  m_sv, m_rd;
  logic [1:0]  m_mode;
  int          m_cnt;

  typedef struct {
    logic [3:0]  opcode, rs;
    logic [15:0] rs_data;
    logic [3:0]  imm, rd;
    logic        xe;
    logic [3:0]  xr;
    logic [15:0] xd;
    logic        me;
    logic [3:0]  mr;
    logic [15:0] md;
    logic        fl, ev;
    logic [15:0] esi;
    logic [1:0]  emode;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] operand();
    if (FWD && exmem_wr_en && exmem_rd == id_rs_addr && id_rs_addr != 0) return exmem_data;
    if (FWD && memwb_wr_en && memwb_rd == id_rs_addr && id_rs_addr != 0) return memwb_data;
    return id_rs_data;
  endfunction

  function automatic bit shift_op(input logic [3:0] op);
    return op >= 4 && op <= 6;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_si = 0; m_sv = 0; m_rd = 0; m_mode = 0; m_cnt = 0;
  endtask

  task automatic step();
    bit rdy, acc;
    logic [15:0] op;
    #1;
    rdy = !m_valid || ex_ready;
    chk("id_ready", {31'b0, id_ready}, {31'b0, rdy});
    acc = !flush && id_valid && rdy && shift_op(id_opcode);
    op = operand();
    @(posedge clk);
    if (acc) begin
      m_si = op; m_sv = id_imm; m_rd = id_rd_addr;
      m_mode = 2'(id_opcode - 4);
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
    m_valid = flush ? 1'b0 : acc ? 1'b1 : rdy ? 1'b0 : m_valid;
    #1;
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
    chk("Shift_In", {16'b0, Shift_In}, {16'b0, m_si});
    chk("Shift_Val", {28'b0, Shift_Val}, {28'b0, m_sv});
    chk("Mode", {30'b0, Mode}, {30'b0, m_mode});
    chk("ex_rd", {28'b0, ex_rd}, {28'b0, m_rd});
    chk("shift_cnt", {16'b0, shift_cnt}, m_cnt);
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rs, input logic [15:0] rsd,
                       input logic [3:0] imm, input logic [3:0] rd, input logic rdy, input logic fl);
    id_valid = 1; id_opcode = op; id_rs_addr = rs; id_rs_data = rsd;
    id_imm = imm; id_rd_addr = rd; ex_ready = rdy; flush = fl;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ex_valid"}, {31'b0, ex_valid}, 0);
    chk({tag, "_Shift_In"}, {16'b0, Shift_In}, 0);
    chk({tag, "_Shift_Val"}, {28'b0, Shift_Val}, 0);
    chk({tag, "_Mode"}, {30'b0, Mode}, 0);
    chk({tag, "_ex_rd"}, {28'b0, ex_rd}, 0);
    chk({tag, "_shift_cnt"}, {16'b0, shift_cnt}, 0);
  endtask

  initial begin
    tbl[0] = '{4'h4, 4'h1, 16'h3333, 4'h4, 4'h2, 0, 4'h0, 16'h0,    0, 4'h0, 16'h0,    0, 1, 16'h3333, 2'd0};
    tbl[1] = '{4'h5, 4'h5, 16'h1234, 4'h7, 4'h3, 1, 4'h5, 16'hAAAA, 1, 4'h5, 16'h5555, 0, 1,
               FWD ? 16'hAAAA : 16'h1234, 2'd1};
    tbl[2] = '{4'h6, 4'h0, 16'h0F0F, 4'h1, 4'h4, 1, 4'h0, 16'hAAAA, 1, 4'h0, 16'h5555, 0, 1, 16'h0F0F, 2'd2};
    tbl[3] = '{4'h4, 4'h3, 16'h7777, 4'h2, 4'h5, 0, 4'h3, 16'hAAAA, 1, 4'h3, 16'h5555, 0, 1,
               FWD ? 16'h5555 : 16'h7777, 2'd0};
    tbl[4] = '{4'h5, 4'h3, 16'h1111, 4'hF, 4'h6, 1, 4'h2, 16'hAAAA, 1, 4'h3, 16'hBEEF, 0, 1,
               FWD ? 16'hBEEF : 16'h1111, 2'd1};
    tbl[5] = '{4'h7, 4'h1, 16'h2222, 4'h3, 4'h7, 0, 4'h0, 16'h0,    0, 4'h0, 16'h0,    0, 0, 16'h0, 2'd0};
    tbl[6] = '{4'h6, 4'h1, 16'h4444, 4'h3, 4'h8, 0, 4'h0, 16'h0,    0, 4'h0, 16'h0,    1, 0, 16'h0, 2'd0};
    tbl[7] = '{4'h0, 4'h1, 16'h5555, 4'h3, 4'h9, 0, 4'h0, 16'h0,    0, 4'h0, 16'h0,    0, 0, 16'h0, 2'd0};

    rst_n = 0; id_valid = 0; id_opcode = 0; id_rs_addr = 0; id_rs_data = 0; id_rd_addr = 0;
    id_imm = 0; flush = 0; exmem_wr_en = 0; exmem_rd = 0; exmem_data = 0;
    memwb_wr_en = 0; memwb_rd = 0; memwb_data = 0; ex_ready = 1;
    model_reset();
    #12 chk_zero("reset");
    #8 rst_n = 1;

    foreach (tbl[i]) begin
      drive(tbl[i].opcode, tbl[i].rs, tbl[i].rs_data, tbl[i].imm, tbl[i].rd, 1'b1, tbl[i].fl);
      exmem_wr_en = tbl[i].xe; exmem_rd = tbl[i].xr; exmem_data = tbl[i].xd;
      memwb_wr_en = tbl[i].me; memwb_rd = tbl[i].mr; memwb_data = tbl[i].md;
      step();
      chk($sformatf("tbl%0d_valid", i), {31'b0, ex_valid}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_si", i), {16'b0, Shift_In}, {16'b0, tbl[i].esi});
        chk($sformatf("tbl%0d_mode", i), {30'b0, Mode}, {30'b0, tbl[i].emode});
      end
    end
    exmem_wr_en = 0; memwb_wr_en = 0;

    drive(4'h4, 4'h1, 16'h3333, 4'h4, 4'h2, 1'b1, 1'b0);
    step();
    drive(4'h5, 4'h2, 16'h9999, 4'h8, 4'h3, 1'b0, 1'b0);
    repeat (3) begin
      step();
      chk("stall_si", {16'b0, Shift_In}, 32'h3333);
    end
    ex_ready = 1;
    step();
    chk("stall_release_si", {16'b0, Shift_In}, 32'h9999);

    drive(4'h6, 4'h1, 16'hCAFE, 4'h2, 4'h4, 1'b0, 1'b1);
    step();
    chk("flush_valid", {31'b0, ex_valid}, 0);
    drive(4'h7, 4'h1, 16'hCAFE, 4'h2, 4'h4, 1'b1, 1'b0);
    repeat (2) step();

    drive(4'h4, 4'h1, 16'h3333, 4'h4, 4'h2, 1'b1, 1'b0);
    step();
    ex_ready = 0;
    step();
    #2 rst_n = 0;
    #1 chk_zero("midhold");
    model_reset();
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom % 4) != 0;
      id_opcode = 4'($urandom_range(3, 8));
      id_rs_addr = 4'($urandom % 4); id_rs_data = 16'($urandom);
      id_rd_addr = 4'($urandom); id_imm = 4'($urandom);
      flush = ($urandom % 10) == 0;
      exmem_wr_en = 1'($urandom); exmem_rd = 4'($urandom % 4); exmem_data = 16'($urandom);
      memwb_wr_en = 1'($urandom); memwb_rd = 4'($urandom % 4); memwb_data = 16'($urandom);
      ex_ready = ($urandom % 3) != 0;
      step();
    end

    exmem_wr_en = 0; memwb_wr_en = 0;
    drive(4'h5, 4'h1, 16'h8001, 4'h1, 4'h2, 1'b1, 1'b0);
    step();
    while (m_cnt < 65534) begin
      @(posedge clk);
      m_cnt++;
    end
    #1 chk("sat_pre", {16'b0, shift_cnt}, 32'hFFFE);
    step();
    chk("sat_max", {16'b0, shift_cnt}, 32'hFFFF);
    step();
    chk("sat_hold", {16'b0, shift_cnt}, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
